// File: rtl/store_buffer.sv
// store_buffer: formats SB/SH/SW stores from the execute stage and queues
// them in a FIFO that drains to the data-memory write port over valid/ready.
// Optional macro STORE_BUF_FWD_EN enables the pending-store hit detector on
// fwd_addr/fwd_pending; without it fwd_pending is tied low.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    input  logic [2:0]                 st_funct3,
    output logic                       st_error,
    output logic                       mem_wr_valid,
    input  logic                       mem_wr_ready,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [31:0]                mem_wr_data,
    output logic [3:0]                 mem_wr_be,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    // Store is legal when funct3 is SB/SH/SW and the address is naturally aligned.
    function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (lo[0] == 1'b0);
            3'b010:  ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate the stored byte/halfword across all lanes it could occupy.
    function automatic logic [31:0] fmt_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {4{d[7:0]}};
            3'b001:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Byte enables select the lanes actually written.
    function automatic logic [3:0] fmt_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] r;
        case (f3)
            3'b000:  r = 4'b0001 << lo;
            3'b001:  r = lo[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    logic [WA_W-1:0]  wa_mem_r   [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [3:0]       be_mem_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             st_error_r;
    logic             legal_s;
    logic             st_ready_s;
    logic             enq_s;
    logic             deq_s;
    logic             valid_s;

    assign legal_s    = is_legal(st_funct3, st_addr[1:0]);
    // A full buffer never accepts, even if the head leaves this cycle.
    assign st_ready_s = (count_r < CNT_W'(DEPTH));
    assign valid_s    = (count_r != {CNT_W{1'b0}});
    assign enq_s      = st_valid && st_ready_s && legal_s;
    assign deq_s      = valid_s && mem_wr_ready;

    assign st_ready     = st_ready_s;
    assign st_error     = st_error_r;
    assign empty        = !valid_s;
    assign count        = count_r;
    assign mem_wr_valid = valid_s;
    assign mem_wr_addr  = {wa_mem_r[rd_ptr_r], 2'b00};
    assign mem_wr_data  = data_mem_r[rd_ptr_r];
    assign mem_wr_be    = be_mem_r[rd_ptr_r];

    // Occupancy next-state from the enqueue/dequeue pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({enq_s, deq_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Queue storage; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            wa_mem_r[wr_ptr_r]   <= st_addr[ADDR_W-1:2];
            data_mem_r[wr_ptr_r] <= fmt_data(st_funct3, st_data);
            be_mem_r[wr_ptr_r]   <= fmt_be(st_funct3, st_addr[1:0]);
        end
    end

    // Pointers, occupancy and the one-cycle illegal-store flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            st_error_r <= 1'b0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r    <= count_nxt_s;
            st_error_r <= st_valid && st_ready_s && !legal_s;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic             fwd_hit_s;
    logic [PTR_W-1:0] fwd_off_s;

    // Any occupied entry (head included) on the load's word raises the hit;
    // the store being enqueued this cycle is not yet in storage.
    always_comb begin
        fwd_hit_s = 1'b0;
        fwd_off_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd_off_s = PTR_W'(i) - rd_ptr_r;
            if (({1'b0, fwd_off_s} < count_r) &&
                (wa_mem_r[i] == fwd_addr[ADDR_W-1:2])) begin
                fwd_hit_s = 1'b1;
            end else begin
                fwd_hit_s = fwd_hit_s;
            end
        end
    end

    assign fwd_pending = fwd_hit_s;
`else
    logic unused_fwd_s;

    assign unused_fwd_s = ^fwd_addr;
    assign fwd_pending  = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_error;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        empty;
    logic [2:0]  count;
    logic [31:0] fwd_addr;
    logic        fwd_pending;

    int  checks   = 0;
    int  failures = 0;
    wr_t sb_q[$];
    logic exp_hit;

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_funct3(st_funct3), .st_error(st_error),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be),
        .empty(empty), .count(count), .fwd_addr(fwd_addr), .fwd_pending(fwd_pending)
    );

    always #5 clk = ~clk;

    // Scoreboard: every memory handshake must match the oldest expected store.
    always @(negedge clk) begin
        if (!reset && mem_wr_valid && mem_wr_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL drain_unexpected got addr=%h data=%h be=%b, expected no write",
                         mem_wr_addr, mem_wr_data, mem_wr_be);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                if ({mem_wr_addr, mem_wr_data, mem_wr_be} !== e) begin
                    failures++;
                    $display("FAIL drain_order got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                             mem_wr_addr, mem_wr_data, mem_wr_be, e.addr, e.data, e.be);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        st_valid  = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!empty && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!empty || sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got empty=%b pending_expected=%0d, expected empty=1 pending_expected=0",
                     name, empty, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; st_valid = 1'b0; mem_wr_ready = 1'b0; fwd_addr = 32'h0;
        st_addr = 32'h0; st_data = 32'h0; st_funct3 = 3'b010;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({count, empty, mem_wr_valid, st_error, st_ready} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got count=%0d empty=%b valid=%b err=%b ready=%b, expected 0 1 0 0 1",
                     count, empty, mem_wr_valid, st_error, st_ready);
        end
    endtask

    task automatic test_sw();
        mem_wr_ready = 1'b1;
        drive(32'h100, 32'hDEADBEEF, 3'b010);
        sb_q.push_back('{32'h100, 32'hDEADBEEF, 4'b1111});
        tick();
        st_valid = 1'b0;
        checks++;
        if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h100) begin
            failures++;
            $display("FAIL sw_latency got valid=%b addr=%h, expected valid=1 addr=00000100",
                     mem_wr_valid, mem_wr_addr);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL sw_empty got empty=%b, expected 1", empty);
        end
    endtask

    task automatic test_format();
        mem_wr_ready = 1'b1;
        drive(32'h203, 32'h000000A5, 3'b000);
        sb_q.push_back('{32'h200, 32'hA5A5A5A5, 4'b1000});
        tick();
        drive(32'h202, 32'h00001234, 3'b001);
        sb_q.push_back('{32'h200, 32'h12341234, 4'b1100});
        tick();
        drive(32'h201, 32'hFFFF_FF3C, 3'b000);
        sb_q.push_back('{32'h200, 32'h3C3C3C3C, 4'b0010});
        tick();
        drive(32'h300, 32'h0000BEEF, 3'b001);
        sb_q.push_back('{32'h300, 32'hBEEFBEEF, 4'b0011});
        tick();
        st_valid = 1'b0;
        wait_empty("format");
    endtask

    task automatic test_full();
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h400 + 32'(i * 4), 32'h11110000 + 32'(i), 3'b010);
            sb_q.push_back('{32'h400 + 32'(i * 4), 32'h11110000 + 32'(i), 4'b1111});
            tick();
        end
        drive(32'h410, 32'h11110004, 3'b010);
        checks++;
        if (count !== 3'd4 || st_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state got count=%0d ready=%b, expected count=4 ready=0", count, st_ready);
        end
        tick();
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL full_hold got count=%0d, expected 4", count);
        end
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || st_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_no_passthru got count=%0d ready=%b, expected count=3 ready=1", count, st_ready);
        end
        sb_q.push_back('{32'h410, 32'h11110004, 4'b1111});
        tick();
        st_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL full_fifth got count=%0d, expected 4", count);
        end
        mem_wr_ready = 1'b1;
        wait_empty("full");
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [3];
        logic [2:0]  f3s   [3];
        addrs[0] = 32'h102; f3s[0] = 3'b010;
        addrs[1] = 32'h100; f3s[1] = 3'b011;
        addrs[2] = 32'h105; f3s[2] = 3'b001;
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], 32'hCAFEF00D, f3s[i]);
            tick();
            st_valid = 1'b0;
            checks++;
            if (st_error !== 1'b1 || count !== 3'd0 || mem_wr_valid !== 1'b0) begin
                failures++;
                $display("FAIL illegal_%0d got err=%b count=%0d valid=%b, expected err=1 count=0 valid=0",
                         i, st_error, count, mem_wr_valid);
            end
            tick();
            checks++;
            if (st_error !== 1'b0) begin
                failures++;
                $display("FAIL illegal_pulse_%0d got err=%b, expected 0", i, st_error);
            end
        end
    endtask

    task automatic test_fwd();
`ifdef STORE_BUF_FWD_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        mem_wr_ready = 1'b0;
        drive(32'h30, 32'h0000005A, 3'b000);
        sb_q.push_back('{32'h30, 32'h5A5A5A5A, 4'b0001});
        tick();
        st_valid = 1'b0;
        fwd_addr = 32'h33;
        #1;
        checks++;
        if (fwd_pending !== exp_hit) begin
            failures++;
            $display("FAIL fwd_hit got %b, expected %b", fwd_pending, exp_hit);
        end
        fwd_addr = 32'h34;
        #1;
        checks++;
        if (fwd_pending !== 1'b0) begin
            failures++;
            $display("FAIL fwd_miss got %b, expected 0", fwd_pending);
        end
        fwd_addr = 32'h40;
        drive(32'h40, 32'h00000007, 3'b000);
        #1;
        checks++;
        if (fwd_pending !== 1'b0) begin
            failures++;
            $display("FAIL fwd_enq_excluded got %b, expected 0", fwd_pending);
        end
        sb_q.push_back('{32'h40, 32'h07070707, 4'b0001});
        tick();
        st_valid = 1'b0;
        checks++;
        if (fwd_pending !== exp_hit) begin
            failures++;
            $display("FAIL fwd_second_entry got %b, expected %b", fwd_pending, exp_hit);
        end
        mem_wr_ready = 1'b1;
        wait_empty("fwd");
        mem_wr_ready = 1'b0;
        fwd_addr = 32'h0;
    endtask

    task automatic test_reset_mid();
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h500 + 32'(i * 4), 32'h55550000 + 32'(i), 3'b010);
            tick();
        end
        st_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL midreset_fill got count=%0d, expected 3", count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || mem_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear got count=%0d empty=%b valid=%b, expected 0 1 0",
                     count, empty, mem_wr_valid);
        end
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_wr_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_format();
        test_full();
        test_illegal();
        test_fwd();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
